// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache with per-set round-robin replacement, critical-word
// return on refill, deferred fence.i and hit/miss event pulses.
module icache_set_assoc #(
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 4,
    parameter int WAYS        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_valid_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_ready_o,
    output logic [31:0] ifu_data_o,
    input  logic        ifu_fence_i,
    output logic        Icache_r_valid_o,
    output logic [31:0] Icache_r_addr_o,
    output logic [7:0]  Icache_r_len_o,
    input  logic        Icache_r_ready_i,
    input  logic [31:0] Icache_r_data_i,
    input  logic        Icache_r_last_i,
    output logic        hit_o,
    output logic        miss_o
);
    localparam int WORDS  = 1 << (OFFSET_BITS - 2);
    localparam int SETS   = 1 << INDEX_BITS;
    localparam int TAG_W  = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int WORD_W = OFFSET_BITS - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, HIT, REFILL, RESP, FENCE} state_t;

    state_t state, state_next;
    logic   fence_pending;

    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  ptr      [SETS];
    logic [TAG_W-1:0]  tag_ram  [SETS][WAYS];
    logic [31:0]       data_ram [SETS][WAYS][WORDS];

    logic [31:0]       req_addr;
    logic [31:0]       crit_word;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              victim_by_ptr;
    logic [WORD_W-1:0] cnt;

    logic [INDEX_BITS-1:0] in_idx, req_idx;
    logic [TAG_W-1:0]      in_tag, req_tag;
    logic [WORD_W-1:0]     req_word;
    logic                  lookup_hit, inv_found;
    logic [WAY_W-1:0]      lookup_way, inv_way;
    logic                  beat, beat_last;
    logic                  unused_bits;

    assign in_idx   = ifu_addr_i[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign in_tag   = ifu_addr_i[31:OFFSET_BITS+INDEX_BITS];
    assign req_idx  = req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag  = req_addr[31:OFFSET_BITS+INDEX_BITS];
    assign req_word = req_addr[OFFSET_BITS-1:2];
    assign unused_bits = ^req_addr[1:0];

    assign beat      = (state == REFILL) && Icache_r_ready_i;
    assign beat_last = beat && Icache_r_last_i;

    // Parallel tag compare and victim choice on the incoming address (used only in IDLE).
    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[in_idx][w] && (tag_ram[in_idx][w] == in_tag)) begin
                lookup_hit = 1'b1;
                lookup_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way is the one left selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[in_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ifu_fence_i || fence_pending) state_next = FENCE;
                else if (ifu_valid_i)              state_next = lookup_hit ? HIT : REFILL;
            end
            HIT:     state_next = IDLE;
            REFILL:  if (beat_last) state_next = RESP;
            RESP:    state_next = IDLE;
            FENCE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            fence_pending <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                ptr[s]   <= '0;
            end
        end else begin
            state <= state_next;
            // A pending fence is always taken from IDLE, so leaving IDLE retires it.
            if (state == IDLE)   fence_pending <= 1'b0;
            else if (ifu_fence_i) fence_pending <= 1'b1;
            if (state == FENCE) begin
                for (int s = 0; s < SETS; s++) begin
                    valid[s] <= '0;
                    ptr[s]   <= '0;
                end
            end else if (beat_last) begin
                valid[req_idx][victim] <= 1'b1;
                if (victim_by_ptr)
                    ptr[req_idx] <= (ptr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr[req_idx] + 1'b1;
            end
        end
    end

    // Request latch and refill datapath; tag and data storage carry no reset.
    always_ff @(posedge clock) begin
        if (state == IDLE) begin
            req_addr      <= ifu_addr_i;
            hit_way       <= lookup_way;
            victim        <= inv_found ? inv_way : ptr[in_idx];
            victim_by_ptr <= !inv_found;
            cnt           <= '0;
        end
        if (beat) begin
            data_ram[req_idx][victim][cnt] <= Icache_r_data_i;
            tag_ram[req_idx][victim]       <= req_tag;
            if (cnt == req_word) crit_word <= Icache_r_data_i;
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        ifu_ready_o      = (state == HIT) || (state == RESP);
        hit_o            = (state == HIT);
        miss_o           = (state == RESP);
        Icache_r_valid_o = (state == REFILL);
        Icache_r_len_o   = 8'(WORDS - 1);
        Icache_r_addr_o  = '0;
        ifu_data_o       = '0;
        if (state == REFILL) Icache_r_addr_o = {req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        if (state == HIT)       ifu_data_o = data_ram[req_idx][hit_way][req_word];
        else if (state == RESP) ifu_data_o = crit_word;
    end
endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: a default instance plus two parameter-sweep
// instances share the bus; the request and fence inputs are routed to one selected instance.
module tb_icache_set_assoc;
    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_valid;
    logic [31:0] ifu_addr;
    logic        ifu_fence;
    logic        r_ready;
    logic [31:0] r_data;
    logic        r_last;
    int          sel;

    logic [2:0]  vld, fen, rdy, rv, hit, miss;
    logic [31:0] dat   [3];
    logic [31:0] raddr [3];
    logic [7:0]  rlen  [3];

    always #5 clock = ~clock;

    assign vld[0] = ifu_valid && (sel == 0);
    assign vld[1] = ifu_valid && (sel == 1);
    assign vld[2] = ifu_valid && (sel == 2);
    assign fen[0] = ifu_fence && (sel == 0);
    assign fen[1] = ifu_fence && (sel == 1);
    assign fen[2] = ifu_fence && (sel == 2);

    icache_set_assoc u_dut0 (
        .clock(clock), .reset(reset), .ifu_valid_i(vld[0]), .ifu_addr_i(ifu_addr),
        .ifu_ready_o(rdy[0]), .ifu_data_o(dat[0]), .ifu_fence_i(fen[0]),
        .Icache_r_valid_o(rv[0]), .Icache_r_addr_o(raddr[0]), .Icache_r_len_o(rlen[0]),
        .Icache_r_ready_i(r_ready), .Icache_r_data_i(r_data), .Icache_r_last_i(r_last),
        .hit_o(hit[0]), .miss_o(miss[0]));

    icache_set_assoc #(.OFFSET_BITS(5), .INDEX_BITS(4), .WAYS(1)) u_dut1 (
        .clock(clock), .reset(reset), .ifu_valid_i(vld[1]), .ifu_addr_i(ifu_addr),
        .ifu_ready_o(rdy[1]), .ifu_data_o(dat[1]), .ifu_fence_i(fen[1]),
        .Icache_r_valid_o(rv[1]), .Icache_r_addr_o(raddr[1]), .Icache_r_len_o(rlen[1]),
        .Icache_r_ready_i(r_ready), .Icache_r_data_i(r_data), .Icache_r_last_i(r_last),
        .hit_o(hit[1]), .miss_o(miss[1]));

    icache_set_assoc #(.OFFSET_BITS(4), .INDEX_BITS(2), .WAYS(4)) u_dut2 (
        .clock(clock), .reset(reset), .ifu_valid_i(vld[2]), .ifu_addr_i(ifu_addr),
        .ifu_ready_o(rdy[2]), .ifu_data_o(dat[2]), .ifu_fence_i(fen[2]),
        .Icache_r_valid_o(rv[2]), .Icache_r_addr_o(raddr[2]), .Icache_r_len_o(rlen[2]),
        .Icache_r_ready_i(r_ready), .Icache_r_data_i(r_data), .Icache_r_last_i(r_last),
        .hit_o(hit[2]), .miss_o(miss[2]));

    typedef struct {
        int          sel;
        logic [31:0] addr;
        bit          miss;
        logic [31:0] base;
        logic [31:0] exp_data;
        logic [31:0] exp_raddr;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [31:0] a);
        @(negedge clock);
        ifu_valid = 1'b1;
        ifu_addr  = a;
        @(negedge clock);
        ifu_valid = 1'b0;
        ifu_addr  = 32'hDEAD_BEEF;
    endtask

    task automatic expect_hit(input string name, input logic [31:0] exp);
        check({name, " ready"}, 32'(rdy[sel]), 32'd1);
        check({name, " hit_o"}, 32'(hit[sel]), 32'd1);
        check({name, " miss_o"}, 32'(miss[sel]), 32'd0);
        check({name, " data"}, dat[sel], exp);
    endtask

    task automatic expect_resp(input string name, input logic [31:0] exp);
        check({name, " ready"}, 32'(rdy[sel]), 32'd1);
        check({name, " miss_o"}, 32'(miss[sel]), 32'd1);
        check({name, " hit_o"}, 32'(hit[sel]), 32'd0);
        check({name, " data"}, dat[sel], exp);
        check({name, " r_valid drop"}, 32'(rv[sel]), 32'd0);
    endtask

    // Called one cycle after accept: checks the burst request, feeds all beats with a
    // one-cycle stall after beat 0, then checks the miss response.
    task automatic refill(input string name, input logic [31:0] ra, input logic [31:0] base,
                          input logic [31:0] crit);
        int n;
        n = (sel == 1) ? 8 : 4;
        check({name, " r_valid"}, 32'(rv[sel]), 32'd1);
        check({name, " r_addr"}, raddr[sel], ra);
        check({name, " r_len"}, 32'(rlen[sel]), 32'(n - 1));
        check({name, " no early ready"}, 32'(rdy[sel]), 32'd0);
        for (int i = 0; i < n; i++) begin
            r_ready = 1'b1;
            r_data  = base + 32'(i);
            r_last  = (i == n - 1);
            @(negedge clock);
            r_ready = 1'b0;
            r_last  = 1'b0;
            if (i == 0) begin
                @(negedge clock);
                check({name, " r_valid in stall"}, 32'(rv[sel]), 32'd1);
            end
        end
        expect_resp(name, crit);
    endtask

    logic [7:0] len_exp [3];

    initial begin
        reset = 1'b1; ifu_valid = 1'b0; ifu_addr = '0; ifu_fence = 1'b0;
        r_ready = 1'b0; r_data = '0; r_last = 1'b0; sel = 0;
        len_exp[0] = 8'd3; len_exp[1] = 8'd7; len_exp[2] = 8'd3;

        //          sel  addr           miss  base           exp_data       exp_raddr
        vq.push_back('{0, 32'h8000_0008, 1'b1, 32'hD000_0000, 32'hD000_0002, 32'h8000_0000});
        vq.push_back('{0, 32'h8000_000C, 1'b0, 32'h0,         32'hD000_0003, 32'h0});
        vq.push_back('{0, 32'h8000_0100, 1'b1, 32'hD100_0000, 32'hD100_0000, 32'h8000_0100});
        vq.push_back('{0, 32'h8000_0000, 1'b0, 32'h0,         32'hD000_0000, 32'h0});
        vq.push_back('{0, 32'h8000_0104, 1'b0, 32'h0,         32'hD100_0001, 32'h0});
        vq.push_back('{0, 32'h8000_0200, 1'b1, 32'hD200_0000, 32'hD200_0000, 32'h8000_0200});
        vq.push_back('{0, 32'h8000_0100, 1'b0, 32'h0,         32'hD100_0000, 32'h0});
        vq.push_back('{0, 32'h8000_0000, 1'b1, 32'hD300_0000, 32'hD300_0000, 32'h8000_0000});
        vq.push_back('{0, 32'h8000_0208, 1'b0, 32'h0,         32'hD200_0002, 32'h0});
        vq.push_back('{0, 32'h8000_0104, 1'b1, 32'hD400_0000, 32'hD400_0001, 32'h8000_0100});
        vq.push_back('{0, 32'h8000_000C, 1'b0, 32'h0,         32'hD300_0003, 32'h0});
        vq.push_back('{1, 32'h8000_0014, 1'b1, 32'hE000_0000, 32'hE000_0005, 32'h8000_0000});
        vq.push_back('{1, 32'h8000_001C, 1'b0, 32'h0,         32'hE000_0007, 32'h0});
        vq.push_back('{1, 32'h8000_0200, 1'b1, 32'hE100_0000, 32'hE100_0000, 32'h8000_0200});
        vq.push_back('{1, 32'h8000_0014, 1'b1, 32'hE200_0000, 32'hE200_0005, 32'h8000_0000});
        vq.push_back('{2, 32'h8000_0000, 1'b1, 32'hF000_0000, 32'hF000_0000, 32'h8000_0000});
        vq.push_back('{2, 32'h8000_0104, 1'b1, 32'hF100_0000, 32'hF100_0001, 32'h8000_0100});
        vq.push_back('{2, 32'h8000_0208, 1'b1, 32'hF200_0000, 32'hF200_0002, 32'h8000_0200});
        vq.push_back('{2, 32'h8000_030C, 1'b1, 32'hF300_0000, 32'hF300_0003, 32'h8000_0300});
        vq.push_back('{2, 32'h8000_0400, 1'b1, 32'hF400_0000, 32'hF400_0000, 32'h8000_0400});
        vq.push_back('{2, 32'h8000_0104, 1'b0, 32'h0,         32'hF100_0001, 32'h0});
        vq.push_back('{2, 32'h8000_0400, 1'b0, 32'h0,         32'hF400_0000, 32'h0});
        vq.push_back('{2, 32'h8000_0000, 1'b1, 32'hF500_0000, 32'hF500_0000, 32'h8000_0000});
        vq.push_back('{2, 32'h8000_0100, 1'b1, 32'hF600_0000, 32'hF600_0000, 32'h8000_0100});
        vq.push_back('{2, 32'h8000_030C, 1'b0, 32'h0,         32'hF300_0003, 32'h0});
        vq.push_back('{2, 32'h8000_0200, 1'b1, 32'hF700_0000, 32'hF700_0000, 32'h8000_0200});
        vq.push_back('{2, 32'h8000_0400, 1'b0, 32'h0,         32'hF400_0000, 32'h0});
        vq.push_back('{2, 32'h8000_0304, 1'b1, 32'hF800_0000, 32'hF800_0001, 32'h8000_0300});

        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d ready", k), 32'(rdy[k]), 32'd0);
            check($sformatf("reset%0d data", k), dat[k], 32'd0);
            check($sformatf("reset%0d r_valid", k), 32'(rv[k]), 32'd0);
            check($sformatf("reset%0d r_addr", k), raddr[k], 32'd0);
            check($sformatf("reset%0d hit/miss", k), 32'({hit[k], miss[k]}), 32'd0);
            check($sformatf("reset%0d r_len", k), 32'(rlen[k]), 32'(len_exp[k]));
        end
        reset = 1'b0;

        foreach (vq[i]) begin
            sel = vq[i].sel;
            accept(vq[i].addr);
            if (vq[i].miss)
                refill($sformatf("vec%0d miss", i), vq[i].exp_raddr, vq[i].base, vq[i].exp_data);
            else
                expect_hit($sformatf("vec%0d hit", i), vq[i].exp_data);
        end

        // Fence in IDLE with a simultaneous (would-hit) request: fence wins, one FENCE cycle.
        sel = 0;
        @(negedge clock);
        ifu_fence = 1'b1; ifu_valid = 1'b1; ifu_addr = 32'h8000_0004;
        @(negedge clock);
        ifu_fence = 1'b0;
        check("fence idle not accepted", 32'(rdy[0]), 32'd0);
        @(negedge clock);
        check("fence idle back to idle", 32'(rv[0]), 32'd0);
        @(negedge clock);
        ifu_valid = 1'b0; ifu_addr = 32'hDEAD_BEEF;
        refill("fence idle refetch", 32'h8000_0000, 32'hC000_0000, 32'hC000_0001);

        // Fence arriving at beat 1 of a refill.
        accept(32'h8000_0308);
        check("fence refill r_valid", 32'(rv[0]), 32'd1);
        r_ready = 1'b1; r_data = 32'hC100_0000;
        @(negedge clock);
        r_data = 32'hC100_0001; ifu_fence = 1'b1;
        @(negedge clock);
        ifu_fence = 1'b0; r_data = 32'hC100_0002;
        @(negedge clock);
        r_data = 32'hC100_0003; r_last = 1'b1;
        @(negedge clock);
        r_ready = 1'b0; r_last = 1'b0;
        expect_resp("fence refill", 32'hC100_0002);
        ifu_valid = 1'b1; ifu_addr = 32'h8000_0308;
        @(negedge clock);
        check("deferred fence idle", 32'(rdy[0]), 32'd0);
        @(negedge clock);
        check("deferred fence runs first", 32'(rdy[0]), 32'd0);
        check("deferred fence no hit", 32'(hit[0]), 32'd0);
        @(negedge clock);
        check("deferred fence no req yet", 32'(rv[0]), 32'd0);
        @(negedge clock);
        ifu_valid = 1'b0; ifu_addr = 32'hDEAD_BEEF;
        refill("deferred fence refetch", 32'h8000_0300, 32'hC200_0000, 32'hC200_0002);

        // Reset at beat 2 of a refill, then stray beats.
        accept(32'h8000_0008);
        check("reset refill r_valid", 32'(rv[0]), 32'd1);
        r_ready = 1'b1; r_data = 32'hC300_0000;
        @(negedge clock);
        r_data = 32'hC300_0001;
        @(negedge clock);
        r_data = 32'hC300_0002; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid reset ready", 32'(rdy[0]), 32'd0);
        check("mid reset data", dat[0], 32'd0);
        check("mid reset r_valid", 32'(rv[0]), 32'd0);
        check("mid reset r_addr", raddr[0], 32'd0);
        check("mid reset hit/miss", 32'({hit[0], miss[0]}), 32'd0);
        r_data = 32'hC300_0003; r_last = 1'b1;
        @(negedge clock);
        r_ready = 1'b0; r_last = 1'b0;
        check("stray beat no ready", 32'(rdy[0]), 32'd0);
        check("stray beat no miss", 32'(miss[0]), 32'd0);
        check("stray beat r_valid", 32'(rv[0]), 32'd0);
        accept(32'h8000_0308);
        refill("post reset refetch", 32'h8000_0300, 32'hC400_0000, 32'hC400_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
